product_accumulator: RTL and testbench
======================================

// Module: product_accumulator
// PURPOSE
//   Sequential stage directly downstream of the 4x4 carry-save multiplier.
//   - Takes each 8-bit product p over a valid/ready handshake.
//   - Sums CNT consecutive products into one frame total.
//   - Presents the total on a valid/ready output, with a saturation flag.
//   - Together with the multiplier, forms the team's multiply-accumulate (dot-product) datapath.
// PARAMETERS
//   PW   8   product width; matches the multiplier output p[7:0]
//   CNT  4   products per frame; legal range 1..256
//   AW   10  accumulator and out_sum width; must be >= PW
// PORTS
//   clk        input   1    single clock, rising-edge
//   rst        input   1    synchronous reset, active-high
//   clr        input   1    synchronous frame abort, active-high
//   in_valid   input   1    in_p is valid this cycle
//   in_ready   output  1    block accepts in_p this cycle
//   in_p       input   PW   unsigned product from the multiplier
//   out_valid  output  1    out_sum/out_sat are valid
//   out_ready  input   1    consumer takes the result this cycle
//   out_sum    output  AW   frame total, unsigned, saturated
//   out_sat    output  1    frame total clipped at 2^AW-1
// BEHAVIOUR
//   - Clock and reset: one clock; reset is synchronous and active-high.
//   - Reset values: state=ACC, acc=0, cnt=0, out_valid=0, out_sum=0, out_sat=0.
//     in_ready=1 from the first cycle after reset.
//   - FSM states: ACC, HOLD.
//     - ACC: in_ready=1, out_valid=0.
//       - Accept = in_valid & in_ready.
//       - On accept: acc <= sat(acc + in_p), cnt <= cnt+1.
//       - sat(x) = x if x < 2^AW, else 2^AW-1 with the sticky sat bit set.
//       - Sum is computed at AW+1 bits so no wrap-around is possible.
//       - On accept with cnt==CNT-1: out_sum <= sat(acc+in_p), out_sat <= sticky|new-sat,
//         out_valid <= 1, acc/cnt/sticky <= 0, next state HOLD.
//     - HOLD: in_ready=0; out_sum and out_sat held stable while out_valid & !out_ready.
//       - On out_ready: out_valid <= 0, next state ACC.
//       - in_ready stays 0 in that handoff cycle, so there is a one-cycle bubble per frame.
//   - Latency: out_valid rises on the cycle after the CNT-th accept.
//   - Throughput: one product per cycle within a frame; CNT+1 cycles per frame minimum.
//   - in_valid low in ACC: no change; gaps inside a frame are legal.
//   - in_p is ignored when no accept occurs; X on in_p without in_valid must not propagate.
//   - clr:
//     - Any state: next state ACC, acc/cnt/sticky <= 0, out_valid <= 0.
//     - A product presented in the same cycle is dropped.
//     - A HOLD result is discarded.
//   - Priority: rst > clr > handshake.
//   - CNT=1: every accept produces a result and the block alternates ACC/HOLD.
//   - out_sat is meaningful only while out_valid=1; it clears with the next frame result.
// TESTING
//   1. Reset, then 4 accepts of 225 (15*15) back-to-back.
//      -> out_valid in cycle 5, out_sum=900, out_sat=0, in_ready=0 until out_ready.
//   2. Products 0,1,2,3 with one idle cycle between each.
//      -> out_sum=6; no accept is counted during the idle cycles.
//   3. CNT=8, eight products of 225.
//      -> raw 1800 > 1023, so out_sum=1023 and out_sat=1.
//      -> The next frame 1,1,1,1,1,1,1,1 gives out_sum=8, out_sat=0.
//   4. Result pending with out_ready=0 for 5 cycles, in_valid=1 throughout.
//      -> out_sum stable, in_ready=0, no product absorbed.
//      -> out_ready=1 releases; the next frame starts one cycle later.
//   5. After 2 accepts (10, 20), assert clr together with in_valid (in_p=30).
//      -> acc=0, 30 dropped; the next 4 products 1,2,3,4 give out_sum=10.
//   6. Assert rst mid-frame and again during HOLD.
//      -> All outputs return to reset values on the next edge; the first post-reset frame sums correctly.

Source files
------------

// File: rtl/product_accumulator_if.sv
// product_accumulator_if: product input and frame-result handshake bundle
interface product_accumulator_if #(
    parameter int PW = 8,
    parameter int AW = 10
);
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_p;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_sum;
    logic          out_sat;
    modport master (output in_valid, in_p, out_ready, input in_ready, out_valid, out_sum, out_sat);
    modport slave  (input in_valid, in_p, out_ready, output in_ready, out_valid, out_sum, out_sat);
endinterface

// File: rtl/product_accumulator.sv
// product_accumulator: sums CNT multiplier products per frame into a saturating total
module product_accumulator #(
    parameter int PW  = 8,
    parameter int CNT = 4,
    parameter int AW  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    product_accumulator_if.slave  bus
);
    localparam int CW = (CNT > 1) ? $clog2(CNT) : 1;
    localparam logic [0:0] ACC  = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sticky_q, sticky_d;
    logic          out_valid_q, out_valid_d;
    logic [AW-1:0] out_sum_q, out_sum_d;
    logic          out_sat_q, out_sat_d;
    logic [AW:0]   sum;
    logic          sat_now;
    logic [AW-1:0] sat_val;
    logic          accept;
    logic          last;

    assign bus.in_ready  = (state_q == ACC);
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_sat   = out_sat_q;

    // Next-state: clr aborts the frame, otherwise accumulate in ACC and hand off in HOLD
    always_comb begin
        sum         = {1'b0, acc_q} + (AW+1)'(bus.in_p);
        sat_now     = sum[AW];
        sat_val     = sat_now ? '1 : sum[AW-1:0];
        accept      = (state_q == ACC) && bus.in_valid;
        last        = (cnt_q == CW'(CNT - 1));
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sticky_d    = sticky_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_sat_d   = out_sat_q;
        if (clr) begin
            state_d     = ACC;
            acc_d       = '0;
            cnt_d       = '0;
            sticky_d    = 1'b0;
            out_valid_d = 1'b0;
        end else if (accept && last) begin
            out_sum_d   = sat_val;
            out_sat_d   = sticky_q | sat_now;
            out_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
            sticky_d    = 1'b0;
            state_d     = HOLD;
        end else if (accept) begin
            acc_d    = sat_val;
            cnt_d    = cnt_q + CW'(1);
            sticky_d = sticky_q | sat_now;
        end else if ((state_q == HOLD) && bus.out_ready) begin
            out_valid_d = 1'b0;
            state_d     = ACC;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            sticky_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sticky_q    <= sticky_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_sat_q   <= out_sat_d;
        end
    end
endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: directed checks for CNT=4 and CNT=8 accumulators
module tb_product_accumulator;
    logic clk = 1'b0;
    logic rst;
    logic clr4, clr8;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    product_accumulator_if #(.PW(8), .AW(10)) b4 ();
    product_accumulator_if #(.PW(8), .AW(10)) b8 ();

    product_accumulator #(.PW(8), .CNT(4), .AW(10)) u4 (.clk(clk), .rst(rst), .clr(clr4), .bus(b4));
    product_accumulator #(.PW(8), .CNT(8), .AW(10)) u8 (.clk(clk), .rst(rst), .clr(clr8), .bus(b8));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic put(input logic [7:0] p);
        b4.in_valid = 1'b1;
        b4.in_p     = p;
        @(negedge clk);
        b4.in_valid = 1'b0;
        b4.in_p     = 'x;
    endtask

    task automatic idle();
        b4.in_valid = 1'b0;
        b4.in_p     = 'x;
        @(negedge clk);
    endtask

    task automatic result(input string tag, input int sum, input int sat);
        check({tag, "_valid"}, b4.out_valid, 1);
        check({tag, "_sum"}, b4.out_sum, sum);
        check({tag, "_sat"}, b4.out_sat, sat);
        check({tag, "_rdy"}, b4.in_ready, 0);
    endtask

    task automatic release4();
        b4.out_ready = 1'b1;
        @(negedge clk);
        b4.out_ready = 1'b0;
        check("rel_valid", b4.out_valid, 0);
        check("rel_rdy", b4.in_ready, 1);
    endtask

    task automatic put8(input logic [7:0] p);
        b8.in_valid = 1'b1;
        b8.in_p     = p;
        @(negedge clk);
        b8.in_valid = 1'b0;
        b8.in_p     = 'x;
    endtask

    initial begin
        rst = 1'b1; clr4 = 1'b0; clr8 = 1'b0;
        b4.in_valid = 1'b0; b4.in_p = '0; b4.out_ready = 1'b0;
        b8.in_valid = 1'b0; b8.in_p = '0; b8.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", b4.out_valid, 0);
        check("rst_sum", b4.out_sum, 0);
        check("rst_sat", b4.out_sat, 0);
        check("rst_rdy", b4.in_ready, 1);
        rst = 1'b0;

        // 1: four back-to-back 225s
        for (int i = 0; i < 3; i++) put(8'd225);
        check("t1_early", b4.out_valid, 0);
        put(8'd225);
        result("t1", 900, 0);
        idle();
        result("t1_hold", 900, 0);
        release4();

        // 2: 0,1,2,3 with idle cycles and X on in_p between
        put(8'd0); idle(); put(8'd1); idle(); put(8'd2); idle();
        check("t2_mid", b4.out_valid, 0);
        put(8'd3);
        result("t2", 6, 0);
        release4();

        // 3: CNT=8 saturation then a clean frame
        for (int i = 0; i < 7; i++) put8(8'd225);
        check("t3_early", b8.out_valid, 0);
        put8(8'd225);
        check("t3_valid", b8.out_valid, 1);
        check("t3_sum", b8.out_sum, 1023);
        check("t3_sat", b8.out_sat, 1);
        b8.out_ready = 1'b1; @(negedge clk); b8.out_ready = 1'b0;
        check("t3_rel", b8.out_valid, 0);
        for (int i = 0; i < 8; i++) put8(8'd1);
        check("t3b_sum", b8.out_sum, 8);
        check("t3b_sat", b8.out_sat, 0);
        check("t3b_valid", b8.out_valid, 1);
        b8.out_ready = 1'b1; @(negedge clk); b8.out_ready = 1'b0;

        // 4: backpressure with in_valid held high
        for (int i = 0; i < 4; i++) put(8'd10);
        b4.in_valid = 1'b1; b4.in_p = 8'd50;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            result("t4_stall", 40, 0);
        end
        b4.out_ready = 1'b1;
        @(negedge clk);
        b4.out_ready = 1'b0;
        check("t4_rel_valid", b4.out_valid, 0);
        check("t4_rel_rdy", b4.in_ready, 1);
        for (int i = 0; i < 4; i++) put(8'd50);
        result("t4_next", 200, 0);
        release4();

        // 5: clr drops the frame and the concurrent product
        put(8'd10); put(8'd20);
        clr4 = 1'b1; b4.in_valid = 1'b1; b4.in_p = 8'd30;
        @(negedge clk);
        clr4 = 1'b0; b4.in_valid = 1'b0;
        check("t5_clr_valid", b4.out_valid, 0);
        put(8'd1); put(8'd2); put(8'd3);
        check("t5_early", b4.out_valid, 0);
        put(8'd4);
        result("t5", 10, 0);
        clr4 = 1'b1;
        @(negedge clk);
        clr4 = 1'b0;
        check("t5_hclr_valid", b4.out_valid, 0);
        check("t5_hclr_rdy", b4.in_ready, 1);

        // 6: reset mid-frame and during HOLD
        put(8'd100); put(8'd100);
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        check("t6a_valid", b4.out_valid, 0);
        check("t6a_sum", b4.out_sum, 0);
        check("t6a_rdy", b4.in_ready, 1);
        for (int i = 0; i < 4; i++) put(8'd5);
        result("t6a", 20, 0);
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        check("t6b_valid", b4.out_valid, 0);
        check("t6b_sum", b4.out_sum, 0);
        check("t6b_sat", b4.out_sat, 0);
        check("t6b_rdy", b4.in_ready, 1);
        for (int i = 0; i < 4; i++) put(8'd7);
        result("t6b", 28, 0);
        release4();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
